// File: rtl/program_memory_arbiter.sv
// Shares the program memory read port between core fetch (priority) and a debug burst reader.
// Optional `PM_ARB_STATS_EN adds a saturating fetch-stall counter output (stall_count_o).
module program_memory_arbiter #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          MEMORY_DEPTH = 32,
  parameter int unsigned TEXT_BASE    = 32'h0040_0000,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req_i,
  input  logic [DATA_WIDTH-1:0] fetch_addr_i,
  output logic                  fetch_stall_o,
  output logic                  fetch_valid_o,
  output logic [DATA_WIDTH-1:0] fetch_instr_o,
  input  logic                  dbg_start_i,
  input  logic [DATA_WIDTH-1:0] dbg_addr_i,
  input  logic [7:0]            dbg_len_i,
  output logic                  dbg_busy_o,
  output logic                  dbg_valid_o,
  output logic [DATA_WIDTH-1:0] dbg_data_o,
  output logic                  dbg_done_o,
  output logic                  dbg_err_o,
`ifdef PM_ARB_STATS_EN
  output logic [15:0]           stall_count_o,
`endif
  output logic [DATA_WIDTH-1:0] mem_address_o,
  input  logic [DATA_WIDTH-1:0] mem_instruction_i
);

  localparam int AW = DATA_WIDTH + 2;
  localparam logic [DATA_WIDTH-1:0] BASE    = DATA_WIDTH'(TEXT_BASE);
  localparam logic [AW-1:0]         MEM_END = AW'(TEXT_BASE) + AW'(4 * MEMORY_DEPTH);

  typedef enum logic {D_IDLE, D_RUN} dstate_t;

  dstate_t               state;
  logic [DATA_WIDTH-1:0] dbg_addr_q;
  logic [7:0]            remaining_q;
  logic [3:0]            starve_cnt;
  logic                  pending, dbg_gnt, fetch_gnt, start_bad;
  logic [AW-1:0]         burst_end;

  // Range check is done two bits wider so a burst near the top of the address space cannot wrap.
  assign burst_end = AW'(dbg_addr_i) + AW'({dbg_len_i, 2'b00});
  assign start_bad = (dbg_addr_i[1:0] != 2'b00) || (dbg_addr_i < BASE) || (burst_end > MEM_END);

  assign pending       = (state == D_RUN);
  assign dbg_gnt       = pending && (!fetch_req_i || starve_cnt == 4'(STARVE_LIMIT));
  assign fetch_gnt     = fetch_req_i && !dbg_gnt;
  assign fetch_stall_o = fetch_req_i && dbg_gnt;
  assign mem_address_o = dbg_gnt ? dbg_addr_q : (fetch_gnt ? fetch_addr_i : BASE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= D_IDLE;
      dbg_addr_q  <= '0;
      remaining_q <= '0;
      starve_cnt  <= '0;
      dbg_busy_o  <= 1'b0;
      dbg_done_o  <= 1'b0;
      dbg_err_o   <= 1'b0;
    end else begin
      dbg_done_o <= 1'b0;
      dbg_err_o  <= 1'b0;
      case (state)
        D_IDLE: if (dbg_start_i) begin
          if (start_bad) dbg_err_o <= 1'b1;
          else if (dbg_len_i == 8'd0) dbg_done_o <= 1'b1;
          else begin
            dbg_addr_q  <= dbg_addr_i;
            remaining_q <= dbg_len_i;
            dbg_busy_o  <= 1'b1;
            state       <= D_RUN;
          end
        end
        D_RUN: if (dbg_gnt) begin
          dbg_addr_q  <= dbg_addr_q + DATA_WIDTH'(4);
          remaining_q <= remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            // done lines up with the last read's valid strobe
            dbg_done_o <= 1'b1;
            dbg_busy_o <= 1'b0;
            state      <= D_IDLE;
          end
        end
        default: state <= D_IDLE;
      endcase
      if (!pending || dbg_gnt) starve_cnt <= '0;
      else                     starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid_o <= 1'b0;
      fetch_instr_o <= '0;
      dbg_valid_o   <= 1'b0;
      dbg_data_o    <= '0;
    end else begin
      fetch_valid_o <= fetch_gnt;
      dbg_valid_o   <= dbg_gnt;
      if (fetch_gnt) fetch_instr_o <= mem_instruction_i;
      if (dbg_gnt)   dbg_data_o    <= mem_instruction_i;
    end
  end

`ifdef PM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_count_o <= '0;
    else if (state == D_IDLE && dbg_start_i && !start_bad)
      stall_count_o <= '0;
    else if (fetch_stall_o && stall_count_o != 16'hFFFF)
      stall_count_o <= stall_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Directed bench for program_memory_arbiter with a combinational 32-word program memory model.
module tb_program_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req_i, fetch_stall_o, fetch_valid_o;
  logic [31:0] fetch_addr_i, fetch_instr_o;
  logic        dbg_start_i, dbg_busy_o, dbg_valid_o, dbg_done_o, dbg_err_o;
  logic [31:0] dbg_addr_i, dbg_data_o;
  logic [7:0]  dbg_len_i;
  logic [31:0] mem_address_o, mem_instruction_i;
`ifdef PM_ARB_STATS_EN
  logic [15:0] stall_count_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int vcnt;
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  assign mem_instruction_i = mem[mem_address_o[6:2]];

  program_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_stall_o(fetch_stall_o), .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o),
    .dbg_start_i(dbg_start_i), .dbg_addr_i(dbg_addr_i), .dbg_len_i(dbg_len_i),
    .dbg_busy_o(dbg_busy_o), .dbg_valid_o(dbg_valid_o), .dbg_data_o(dbg_data_o),
    .dbg_done_o(dbg_done_o), .dbg_err_o(dbg_err_o),
`ifdef PM_ARB_STATS_EN
    .stall_count_o(stall_count_o),
`endif
    .mem_address_o(mem_address_o), .mem_instruction_i(mem_instruction_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [7:0] l);
    dbg_start_i = 1'b1;
    dbg_addr_i  = a;
    dbg_len_i   = l;
    tick();
    dbg_start_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_000A;
    reset = 1'b0;
    fetch_req_i = 1'b0; fetch_addr_i = '0;
    dbg_start_i = 1'b0; dbg_addr_i = '0; dbg_len_i = '0;
    tick(); tick();
    chk("rst_fvalid", {31'd0, fetch_valid_o}, 0);
    chk("rst_finstr", fetch_instr_o, 0);
    chk("rst_busy", {31'd0, dbg_busy_o}, 0);
    chk("rst_ddata", dbg_data_o, 0);
    chk("rst_idle_addr", mem_address_o, 32'h0040_0000);
    reset = 1'b1;
    tick();

    // fetch only
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0040_0000;
    #1 chk("f_addr0", mem_address_o, 32'h0040_0000);
    chk("f_stall0", {31'd0, fetch_stall_o}, 0);
    tick();
    chk("f_valid0", {31'd0, fetch_valid_o}, 1);
    chk("f_instr0", fetch_instr_o, 32'h2008_0005);
    fetch_addr_i = 32'h0040_0004;
    tick();
    chk("f_instr1", fetch_instr_o, 32'h2009_000A);
    chk("f_dvalid", {31'd0, dbg_valid_o}, 0);
    fetch_req_i = 1'b0;
    tick();
    chk("f_valid_off", {31'd0, fetch_valid_o}, 0);
    chk("f_instr_hold", fetch_instr_o, 32'h2009_000A);

    // debug only, len 3
    start(32'h0040_0008, 8'd3);
    chk("d_busy", {31'd0, dbg_busy_o}, 1);
    chk("d_addr0", mem_address_o, 32'h0040_0008);
    tick();
    chk("d_data0", dbg_data_o, 32'hA000_0002);
    chk("d_done0", {31'd0, dbg_done_o}, 0);
    chk("d_addr1", mem_address_o, 32'h0040_000C);
    tick();
    chk("d_data1", dbg_data_o, 32'hA000_0003);
    chk("d_addr2", mem_address_o, 32'h0040_0010);
    tick();
    chk("d_valid2", {31'd0, dbg_valid_o}, 1);
    chk("d_data2", dbg_data_o, 32'hA000_0004);
    chk("d_done2", {31'd0, dbg_done_o}, 1);
    chk("d_busy_off", {31'd0, dbg_busy_o}, 0);
    tick();
    chk("d_done_off", {31'd0, dbg_done_o}, 0);
    chk("d_valid_off", {31'd0, dbg_valid_o}, 0);

    // starvation: fetch held, debug len 2 at word 0
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0040_0010;
    dbg_start_i = 1'b1; dbg_addr_i = 32'h0040_0000; dbg_len_i = 8'd2;
    #1 chk("s_stall_accept", {31'd0, fetch_stall_o}, 0);
    tick();
    dbg_start_i = 1'b0;
    chk("s_fvalid_accept", {31'd0, fetch_valid_o}, 1);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("s_stall_c%0d", c), {31'd0, fetch_stall_o}, (c == 5 || c == 10) ? 1 : 0);
      tick();
      chk($sformatf("s_dvalid_c%0d", c), {31'd0, dbg_valid_o}, (c == 5 || c == 10) ? 1 : 0);
      chk($sformatf("s_fvalid_c%0d", c), {31'd0, fetch_valid_o}, (c == 5 || c == 10) ? 0 : 1);
      chk($sformatf("s_done_c%0d", c), {31'd0, dbg_done_o}, (c == 10) ? 1 : 0);
      if (c == 5) chk("s_data0", dbg_data_o, 32'h2008_0005);
    end
    chk("s_data1", dbg_data_o, 32'h2009_000A);
    chk("s_busy_off", {31'd0, dbg_busy_o}, 0);
`ifdef PM_ARB_STATS_EN
    chk("s_stall_count", {16'd0, stall_count_o}, 2);
`endif
    fetch_req_i = 1'b0;

    // rejects and boundary accept
    start(32'h0040_0002, 8'd1);
    chk("r_misalign", {31'd0, dbg_err_o}, 1);
    chk("r_misalign_busy", {31'd0, dbg_busy_o}, 0);
    tick();
    chk("r_err_off", {31'd0, dbg_err_o}, 0);
    start(32'h003F_FFFC, 8'd1);
    chk("r_below", {31'd0, dbg_err_o}, 1);
    start(32'h0040_0078, 8'd3);
    chk("r_over", {31'd0, dbg_err_o}, 1);
    chk("r_over_busy", {31'd0, dbg_busy_o}, 0);
    start(32'h0040_0078, 8'd2);
    chk("r_edge_err", {31'd0, dbg_err_o}, 0);
    chk("r_edge_busy", {31'd0, dbg_busy_o}, 1);
    tick();
    chk("r_edge_data0", dbg_data_o, 32'hA000_001E);
    chk("r_edge_done0", {31'd0, dbg_done_o}, 0);
    tick();
    chk("r_edge_data1", dbg_data_o, 32'hA000_001F);
    chk("r_edge_done1", {31'd0, dbg_done_o}, 1);

    // len 0, then ignored start during a burst
    start(32'h0040_0000, 8'd0);
    chk("z_done", {31'd0, dbg_done_o}, 1);
    chk("z_busy", {31'd0, dbg_busy_o}, 0);
    chk("z_valid", {31'd0, dbg_valid_o}, 0);
    tick();
    chk("z_done_off", {31'd0, dbg_done_o}, 0);
    start(32'h0040_0000, 8'd4);
    vcnt = 0;
    dbg_start_i = 1'b1; dbg_addr_i = 32'h0040_0002; dbg_len_i = 8'd1;
    for (int c = 0; c < 6; c++) begin
      tick();
      dbg_start_i = 1'b0;
      if (dbg_valid_o) vcnt++;
      chk($sformatf("i_err_c%0d", c), {31'd0, dbg_err_o}, 0);
    end
    chk("i_vcount", vcnt, 4);

    // async reset mid-burst
    start(32'h0040_0000, 8'd5);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("a_busy", {31'd0, dbg_busy_o}, 0);
    chk("a_dvalid", {31'd0, dbg_valid_o}, 0);
    chk("a_ddata", dbg_data_o, 0);
    tick();
    chk("a_done", {31'd0, dbg_done_o}, 0);
`ifdef PM_ARB_STATS_EN
    chk("a_stall_count", {16'd0, stall_count_o}, 0);
`endif
    reset = 1'b1;
    fetch_req_i = 1'b1; fetch_addr_i = 32'h0040_0004;
    #1 chk("a_faddr", mem_address_o, 32'h0040_0004);
    tick();
    chk("a_fvalid", {31'd0, fetch_valid_o}, 1);
    chk("a_finstr", fetch_instr_o, 32'h2009_000A);
    chk("a_done_after", {31'd0, dbg_done_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
